// File: rtl/game_sequencer.sv
// game_sequencer: selects the active game, shows a banner on switch, gates button pulses.
// Optional display blanking after inactivity is enabled by GAME_SEQUENCER_IDLE_BLANK_EN.
`default_nettype none

module game_sequencer #(
    parameter int BANNER_CYCLES = 6000000,
    parameter int IDLE_CYCLES   = 16000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_switch_pulse,
    input  logic       btn1_pulse,
    input  logic       btn2_pulse,
    input  logic [3:0] counter_value,
    input  logic [3:0] dice_value,
    input  logic [3:0] hl_value,
    output logic [1:0] game_sel,
    output logic       counter_inc,
    output logic       counter_dec,
    output logic       dice_roll,
    output logic       hl_higher,
    output logic       hl_lower,
    output logic [3:0] display_value,
    output logic       banner_active,
    output logic       idle
);

    localparam logic [23:0] c_banner_last = 24'(BANNER_CYCLES - 1);
    localparam logic [3:0]  c_blank       = 4'd12;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_BANNER = 2'd1
`ifdef GAME_SEQUENCER_IDLE_BLANK_EN
        ,
        ST_IDLE   = 2'd2
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [23:0] banner_cnt_q, banner_cnt_d;
    logic [1:0]  w_sel_next;
    logic        w_any_pulse;
    logic        w_fwd;

    // Three games only: 2 wraps back to 0 so the value 3 is never reached.
    assign w_sel_next  = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
    assign w_any_pulse = btn_switch_pulse | btn1_pulse | btn2_pulse;

`ifdef GAME_SEQUENCER_IDLE_BLANK_EN
    localparam logic [23:0] c_idle_last = 24'(IDLE_CYCLES - 1);
    logic [23:0] idle_cnt_q, idle_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_PLAY;
            sel_q        <= 2'd0;
            banner_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            banner_cnt_q <= banner_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        banner_cnt_d = banner_cnt_q;
`ifdef GAME_SEQUENCER_IDLE_BLANK_EN
        // Held at zero outside PLAY, so every entry to PLAY starts a fresh count.
        idle_cnt_d   = '0;
`endif
        case (state_q)
            ST_PLAY: begin
                if (btn_switch_pulse) begin
                    sel_d        = w_sel_next;
                    state_d      = ST_BANNER;
                    banner_cnt_d = '0;
                end
`ifdef GAME_SEQUENCER_IDLE_BLANK_EN
                else if (!w_any_pulse) begin
                    if (idle_cnt_q == c_idle_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 24'd1;
                    end
                end
`endif
            end
            ST_BANNER: begin
                if (btn_switch_pulse) begin
                    sel_d        = w_sel_next;
                    banner_cnt_d = '0;
                end else if (banner_cnt_q == c_banner_last) begin
                    state_d      = ST_PLAY;
                    banner_cnt_d = '0;
                end else begin
                    banner_cnt_d = banner_cnt_q + 24'd1;
                end
            end
`ifdef GAME_SEQUENCER_IDLE_BLANK_EN
            ST_IDLE: begin
                // The waking pulse is consumed; game selection is untouched.
                if (w_any_pulse) begin
                    state_d = ST_PLAY;
                end
            end
`endif
            default: begin
                state_d = ST_PLAY;
            end
        endcase
    end

    // Reset gating keeps pulse outputs quiet while reset is held.
    assign w_fwd = (state_q == ST_PLAY) & ~btn_switch_pulse & ~reset;

    assign counter_inc = w_fwd & btn1_pulse & (sel_q == 2'd0);
    assign counter_dec = w_fwd & btn2_pulse & (sel_q == 2'd0);
    assign dice_roll   = w_fwd & btn1_pulse & (sel_q == 2'd1);
    assign hl_higher   = w_fwd & btn1_pulse & (sel_q == 2'd2);
    assign hl_lower    = w_fwd & btn2_pulse & (sel_q == 2'd2);

    assign game_sel      = sel_q;
    assign banner_active = (state_q == ST_BANNER);

`ifdef GAME_SEQUENCER_IDLE_BLANK_EN
    assign idle = (state_q == ST_IDLE);
`else
    assign idle = 1'b0;
`endif

    always_comb begin
        display_value = counter_value;
        case (state_q)
            ST_BANNER: display_value = {2'b00, sel_q} + 4'd1;
`ifdef GAME_SEQUENCER_IDLE_BLANK_EN
            ST_IDLE:   display_value = c_blank;
`endif
            default: begin
                case (sel_q)
                    2'd1:    display_value = dice_value;
                    2'd2:    display_value = hl_value;
                    default: display_value = counter_value;
                endcase
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed self-checking bench for game_sequencer (BANNER_CYCLES=4, IDLE_CYCLES=10).
`default_nettype none

module tb_game_sequencer;

    logic       clk;
    logic       reset;
    logic       btn_switch_pulse;
    logic       btn1_pulse;
    logic       btn2_pulse;
    logic [3:0] counter_value;
    logic [3:0] dice_value;
    logic [3:0] hl_value;
    logic [1:0] game_sel;
    logic       counter_inc;
    logic       counter_dec;
    logic       dice_roll;
    logic       hl_higher;
    logic       hl_lower;
    logic [3:0] display_value;
    logic       banner_active;
    logic       idle;

    int n_cmp = 0;
    int n_err = 0;

    game_sequencer #(
        .BANNER_CYCLES (4),
        .IDLE_CYCLES   (10)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .btn_switch_pulse (btn_switch_pulse),
        .btn1_pulse       (btn1_pulse),
        .btn2_pulse       (btn2_pulse),
        .counter_value    (counter_value),
        .dice_value       (dice_value),
        .hl_value         (hl_value),
        .game_sel         (game_sel),
        .counter_inc      (counter_inc),
        .counter_dec      (counter_dec),
        .dice_roll        (dice_roll),
        .hl_higher        (hl_higher),
        .hl_lower         (hl_lower),
        .display_value    (display_value),
        .banner_active    (banner_active),
        .idle             (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are read at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        btn_switch_pulse = 1'b0;
        btn1_pulse       = 1'b0;
        btn2_pulse       = 1'b0;
        reset            = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn1_pulse = 1'b1;
        btn2_pulse = 1'b1;
        @(negedge clk);
        n_cmp++; if (counter_inc !== 1'b0) begin n_err++; $display("FAIL reset_inc: got %0b want 0", counter_inc); end
        n_cmp++; if (counter_dec !== 1'b0) begin n_err++; $display("FAIL reset_dec: got %0b want 0", counter_dec); end
        n_cmp++; if (banner_active !== 1'b0) begin n_err++; $display("FAIL reset_banner: got %0b want 0", banner_active); end
        n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL reset_idle: got %0b want 0", idle); end
        n_cmp++; if (game_sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", game_sel); end
        n_cmp++; if (display_value !== 4'd5) begin n_err++; $display("FAIL reset_disp: got %0d want 5", display_value); end
        apply_reset();
    endtask

    task automatic test_counter();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            btn1_pulse = 1'b1;
            @(negedge clk);
            n_cmp++; if (counter_inc !== 1'b1) begin n_err++; $display("FAIL cnt_inc[%0d]: got %0b want 1", i, counter_inc); end
            n_cmp++; if (dice_roll !== 1'b0) begin n_err++; $display("FAIL cnt_dice[%0d]: got %0b want 0", i, dice_roll); end
            n_cmp++; if (display_value !== 4'd5) begin n_err++; $display("FAIL cnt_disp[%0d]: got %0d want 5", i, display_value); end
            n_cmp++; if (game_sel !== 2'd0) begin n_err++; $display("FAIL cnt_sel[%0d]: got %0d want 0", i, game_sel); end
            step();
            btn1_pulse = 1'b0;
            @(negedge clk);
            n_cmp++; if (counter_inc !== 1'b0) begin n_err++; $display("FAIL cnt_inc_gap[%0d]: got %0b want 0", i, counter_inc); end
            step();
        end
        btn2_pulse = 1'b1;
        @(negedge clk);
        n_cmp++; if (counter_dec !== 1'b1) begin n_err++; $display("FAIL cnt_dec: got %0b want 1", counter_dec); end
        n_cmp++; if (hl_lower !== 1'b0) begin n_err++; $display("FAIL cnt_hl_lower: got %0b want 0", hl_lower); end
        step();
        btn2_pulse = 1'b0;
    endtask

    task automatic test_dice();
        apply_reset();
        btn_switch_pulse = 1'b1;
        step();
        btn_switch_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            btn1_pulse = (i == 1);
            @(negedge clk);
            n_cmp++; if (banner_active !== 1'b1) begin n_err++; $display("FAIL dice_banner[%0d]: got %0b want 1", i, banner_active); end
            n_cmp++; if (game_sel !== 2'd1) begin n_err++; $display("FAIL dice_sel[%0d]: got %0d want 1", i, game_sel); end
            n_cmp++; if (display_value !== 4'd2) begin n_err++; $display("FAIL dice_bdisp[%0d]: got %0d want 2", i, display_value); end
            n_cmp++; if (dice_roll !== 1'b0) begin n_err++; $display("FAIL dice_roll_banner[%0d]: got %0b want 0", i, dice_roll); end
            step();
        end
        btn1_pulse = 1'b0;
        @(negedge clk);
        n_cmp++; if (banner_active !== 1'b0) begin n_err++; $display("FAIL dice_banner_end: got %0b want 0", banner_active); end
        n_cmp++; if (display_value !== 4'd3) begin n_err++; $display("FAIL dice_disp: got %0d want 3", display_value); end
        step();
        btn1_pulse = 1'b1;
        @(negedge clk);
        n_cmp++; if (dice_roll !== 1'b1) begin n_err++; $display("FAIL dice_roll_play: got %0b want 1", dice_roll); end
        n_cmp++; if (counter_inc !== 1'b0) begin n_err++; $display("FAIL dice_no_inc: got %0b want 0", counter_inc); end
        step();
        btn1_pulse = 1'b0;
    endtask

    task automatic test_wrap_and_restart();
        logic [1:0] exp_sel [3];
        exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd0;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            btn_switch_pulse = 1'b1;
            step();
            btn_switch_pulse = 1'b0;
            @(negedge clk);
            n_cmp++; if (game_sel !== exp_sel[k]) begin n_err++; $display("FAIL wrap_sel[%0d]: got %0d want %0d", k, game_sel, exp_sel[k]); end
            for (int j = 0; j < 5; j++) step();
        end
        btn_switch_pulse = 1'b1;
        step();
        btn_switch_pulse = 1'b0;
        step();
        step();
        btn_switch_pulse = 1'b1;
        step();
        btn_switch_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (banner_active !== 1'b1) begin n_err++; $display("FAIL restart_banner[%0d]: got %0b want 1", i, banner_active); end
            step();
        end
        @(negedge clk);
        n_cmp++; if (banner_active !== 1'b0) begin n_err++; $display("FAIL restart_end: got %0b want 0", banner_active); end
        n_cmp++; if (game_sel !== 2'd2) begin n_err++; $display("FAIL restart_sel: got %0d want 2", game_sel); end
        n_cmp++; if (display_value !== 4'd9) begin n_err++; $display("FAIL restart_disp: got %0d want 9", display_value); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        btn_switch_pulse = 1'b1;
        btn1_pulse       = 1'b1;
        @(negedge clk);
        n_cmp++; if (counter_inc !== 1'b0) begin n_err++; $display("FAIL same_inc: got %0b want 0", counter_inc); end
        step();
        btn_switch_pulse = 1'b0;
        btn1_pulse       = 1'b0;
        @(negedge clk);
        n_cmp++; if (game_sel !== 2'd1) begin n_err++; $display("FAIL same_sel: got %0d want 1", game_sel); end
        n_cmp++; if (banner_active !== 1'b1) begin n_err++; $display("FAIL same_banner: got %0b want 1", banner_active); end
        btn_switch_pulse = 1'b1;
        step();
        btn_switch_pulse = 1'b0;
        for (int i = 0; i < 4; i++) step();
        btn1_pulse = 1'b1;
        btn2_pulse = 1'b1;
        @(negedge clk);
        n_cmp++; if (hl_higher !== 1'b1) begin n_err++; $display("FAIL both_higher: got %0b want 1", hl_higher); end
        n_cmp++; if (hl_lower !== 1'b1) begin n_err++; $display("FAIL both_lower: got %0b want 1", hl_lower); end
        n_cmp++; if (counter_dec !== 1'b0) begin n_err++; $display("FAIL both_cnt_dec: got %0b want 0", counter_dec); end
        step();
        btn1_pulse = 1'b0;
        btn2_pulse = 1'b0;
    endtask

    task automatic test_idle();
        apply_reset();
`ifdef GAME_SEQUENCER_IDLE_BLANK_EN
        btn_switch_pulse = 1'b1;
        step();
        step();
        btn_switch_pulse = 1'b0;
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 9; i++) step();
        @(negedge clk);
        n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL idle_early: got %0b want 0", idle); end
        step();
        @(negedge clk);
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL idle_enter: got %0b want 1", idle); end
        n_cmp++; if (display_value !== 4'd12) begin n_err++; $display("FAIL idle_disp: got %0d want 12", display_value); end
        btn2_pulse = 1'b1;
        @(negedge clk);
        n_cmp++; if (hl_lower !== 1'b0) begin n_err++; $display("FAIL idle_hl_lower: got %0b want 0", hl_lower); end
        n_cmp++; if (counter_dec !== 1'b0) begin n_err++; $display("FAIL idle_cnt_dec: got %0b want 0", counter_dec); end
        step();
        btn2_pulse = 1'b0;
        @(negedge clk);
        n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL idle_wake: got %0b want 0", idle); end
        n_cmp++; if (game_sel !== 2'd2) begin n_err++; $display("FAIL idle_sel: got %0d want 2", game_sel); end
        n_cmp++; if (display_value !== 4'd9) begin n_err++; $display("FAIL idle_wake_disp: got %0d want 9", display_value); end
`else
        for (int i = 0; i < 100; i++) step();
        @(negedge clk);
        n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL noidle: got %0b want 0", idle); end
        n_cmp++; if (display_value !== 4'd5) begin n_err++; $display("FAIL noidle_disp: got %0d want 5", display_value); end
`endif
    endtask

    task automatic test_reset_mid_banner();
        apply_reset();
        btn_switch_pulse = 1'b1;
        step();
        step();
        btn_switch_pulse = 1'b0;
        step();
        reset = 1'b1;
        #1;
        n_cmp++; if (game_sel !== 2'd0) begin n_err++; $display("FAIL rmb_sel: got %0d want 0", game_sel); end
        n_cmp++; if (banner_active !== 1'b0) begin n_err++; $display("FAIL rmb_banner: got %0b want 0", banner_active); end
        n_cmp++; if (display_value !== 4'd5) begin n_err++; $display("FAIL rmb_disp: got %0d want 5", display_value); end
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        n_cmp++; if (banner_active !== 1'b0) begin n_err++; $display("FAIL rmb_residual: got %0b want 0", banner_active); end
        btn1_pulse = 1'b1;
        #1;
        n_cmp++; if (counter_inc !== 1'b1) begin n_err++; $display("FAIL rmb_inc: got %0b want 1", counter_inc); end
        step();
        btn1_pulse = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        btn_switch_pulse = 1'b0;
        btn1_pulse       = 1'b0;
        btn2_pulse       = 1'b0;
        counter_value    = 4'd5;
        dice_value       = 4'd3;
        hl_value         = 4'd9;
        #2;
        test_reset();
        test_counter();
        test_dice();
        test_wrap_and_restart();
        test_same_cycle();
        test_idle();
        test_reset_mid_banner();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
